ascii_fifo: RTL and testbench

Buffers keystrokes decoded by the keyboard front end so that a slower consumer loses none of them. The block sits downstream of the ASCII decode stage. It takes a one-cycle key-down strobe plus the decoded 8-bit ASCII code, stores the codes in order in a circular FIFO, and presents them to the consumer through a show-ahead valid/ready interface. It also reports occupancy, full, empty and a sticky overflow flag for the LEDR/HEX debug displays.

---
 rtl/kb_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 36 +++
 rtl/ascii_fifo.sv | 159 +++++++++++++++
 tb/tb_ascii_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// -----------------------------------------------------------------------------
// kb_pkg
// Shared constants for the keyboard path (decode stage and ascii_fifo).
//   ASCII_NUL          : decoder output for an unmapped key; never buffered
//   ASCII_BS           : backspace code, special-cased when
//                        ASCII_FIFO_BS_EN is defined
//   FIFO_DEPTH_DEFAULT : default number of ascii_fifo entries
// -----------------------------------------------------------------------------
package kb_pkg;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_BS  = 8'h08;

  localparam int FIFO_DEPTH_DEFAULT = 16;

  // A decoded code is worth storing only if the decoder mapped it.
  function automatic logic is_mapped(input logic [7:0] code);
    return code != ASCII_NUL;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x 8 storage array for ascii_fifo. It has one synchronous write port
// and one asynchronous read port. The array is not reset, so its contents
// survive a FIFO clear.
// Ports:
//   clk      in   system clock
//   we       in   write enable, sampled on the rising edge
//   wr_addr  in   AW-bit write address
//   wr_data  in   8-bit write data
//   rd_addr  in   AW-bit read address
//   rd_data  out  8-bit data at rd_addr (combinational)
// -----------------------------------------------------------------------------
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ascii_fifo.sv
// -----------------------------------------------------------------------------
// ascii_fifo
// Circular FIFO for decoded keystrokes, with a show-ahead valid/ready output.
// Each cycle a pop is evaluated first. The push is then judged against the
// post-pop occupancy. A push into a full FIFO is dropped and sets a sticky
// overflow flag. A code of 8'h00 (unmapped key) is ignored.
//
// Optional feature (compile-time macro ASCII_FIFO_BS_EN):
//   When defined, a pushed backspace (8'h08) removes the newest unread
//   entry if the post-pop occupancy is non-zero. If nothing is left to erase,
//   the backspace is stored as an ordinary entry so that the consumer can
//   undo a character it has already taken.
//   When undefined, 8'h08 is stored like any other code.
//
// Ports:
//   clk        in   system clock, rising edge
//   i_rst_n    in   asynchronous active-low reset
//   i_sclr     in   synchronous clear, same effect as reset
//   i_key_en   in   one-cycle key-down strobe
//   i_ascii    in   decoded code, sampled when i_key_en=1
//   i_ready    in   consumer accepts the head entry
//   o_valid    out  head entry present on o_ascii
//   o_ascii    out  head entry (8'h00 while empty)
//   o_count    out  occupancy 0..DEPTH
//   o_full     out  o_count == DEPTH
//   o_empty    out  o_count == 0
//   o_overflow out  sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module ascii_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_sclr,
  input  logic                       i_key_en,
  input  logic [7:0]                 i_ascii,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [7:0]                 o_ascii,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    rd_data;

  // ---------------------------------------------------------------------------
  // Per-cycle decisions (pop first, then push against post-pop count)
  // ---------------------------------------------------------------------------
  logic          pop;
  logic          push_req;
  logic [AW:0]   cnt_pp;
  logic          bs_del;
  logic          wr_en;
  logic          ovf_set;

  logic [AW-1:0] rd_ptr_next;
  logic [AW-1:0] wr_ptr_next;
  logic [AW:0]   count_next;

  assign pop      = o_valid & i_ready;
  assign push_req = i_key_en & is_mapped(i_ascii);
  assign cnt_pp   = count - (AW+1)'(pop);

`ifdef ASCII_FIFO_BS_EN
  // A backspace erases the newest entry that is still unread after this
  // cycle's pop. With nothing left to erase, it falls through and is stored.
  assign bs_del = push_req && (i_ascii == ASCII_BS) && (cnt_pp != '0);
`else
  assign bs_del = 1'b0;
`endif

  assign wr_en   = push_req & ~bs_del & (cnt_pp != FULL_CNT);
  assign ovf_set = push_req & ~bs_del & (cnt_pp == FULL_CNT);

  always_comb begin
    rd_ptr_next = rd_ptr + AW'(pop);

    wr_ptr_next = wr_ptr;
    count_next  = cnt_pp;
    unique case ({wr_en, bs_del})
      2'b10: begin
        wr_ptr_next = wr_ptr + AW'(1);
        count_next  = cnt_pp + (AW+1)'(1);
      end
      2'b01: begin
        wr_ptr_next = wr_ptr - AW'(1);
        count_next  = cnt_pp - (AW+1)'(1);
      end
      default: begin
        wr_ptr_next = wr_ptr;
        count_next  = cnt_pp;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers: asynchronous reset plus synchronous clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (i_sclr) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_next;
      wr_ptr   <= wr_ptr_next;
      count    <= count_next;
      overflow <= overflow | ovf_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: not reset, so it holds stale data across clears
  // ---------------------------------------------------------------------------
  fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (i_ascii),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Outputs, derived only from registers and the array
  // ---------------------------------------------------------------------------
  assign o_count    = count;
  assign o_valid    = (count != '0);
  assign o_empty    = (count == '0);
  assign o_full     = (count == FULL_CNT);
  assign o_overflow = overflow;
  // Gate the stale array word so that the head reads as NUL while empty,
  // including immediately after an asynchronous reset.
  assign o_ascii    = o_valid ? rd_data : ASCII_NUL;

endmodule

// File: tb/tb_ascii_fifo.sv
module tb_ascii_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr = 1'b0;
  logic       key_en = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       ready = 1'b0;

  logic       o_valid;
  logic [7:0] o_ascii;
  logic [4:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  ascii_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_sclr     (sclr),
    .i_key_en   (key_en),
    .i_ascii    (ascii),
    .i_ready    (ready),
    .o_valid    (o_valid),
    .o_ascii    (o_ascii),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow)
  );

  // Reference model: the FIFO contents as a queue, oldest at index 0.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || sclr) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      bit erased;
      erased = 1'b0;
      if (q.size() > 0 && ready) void'(q.pop_front());
      if (key_en && ascii != 8'h00) begin
`ifdef ASCII_FIFO_BS_EN
        if (ascii == 8'h08 && q.size() > 0) begin
          void'(q.pop_back());
          erased = 1'b1;
        end
`endif
        if (!erased) begin
          if (q.size() < DEPTH) q.push_back(ascii);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, half a cycle after each edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count", int'(o_count), q.size());
      chk("valid", int'(o_valid), int'(q.size() > 0));
      chk("empty", int'(o_empty), int'(q.size() == 0));
      chk("full", int'(o_full), int'(q.size() == DEPTH));
      chk("overflow", int'(o_overflow), int'(m_ovf));
      if (q.size() > 0) chk("head", int'(o_ascii), int'(q[0]));
    end
  end

  // Advance to just after the next rising edge, then apply new inputs.
  task automatic step(input logic ke, input logic [7:0] a, input logic rd);
    @(posedge clk);
    #1;
    key_en = ke;
    ascii  = a;
    ready  = rd;
    sclr   = 1'b0;
  endtask

  task automatic do_sclr();
    @(posedge clk);
    #1;
    key_en = 1'b0;
    ready  = 1'b0;
    sclr   = 1'b1;
    step(0, 8'h00, 0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_full", int'(o_full), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_ascii", int'(o_ascii), 8'h00);
    chk("rst_ovf", int'(o_overflow), 0);

    // Push A, B, C, then drain them in order
    step(1, 8'h41, 0);
    step(1, 8'h42, 0);
    step(1, 8'h43, 0);
    step(0, 8'h00, 0);
    #1;
    chk("abc_count", int'(o_count), 3);
    chk("abc_head", int'(o_ascii), 8'h41);
    step(0, 8'h00, 1);
    #1;
    chk("pop1", int'(o_ascii), 8'h41);
    step(0, 8'h00, 1);
    #1;
    chk("pop2", int'(o_ascii), 8'h42);
    step(0, 8'h00, 1);
    #1;
    chk("pop3", int'(o_ascii), 8'h43);
    step(0, 8'h00, 0);
    #1;
    chk("drained_empty", int'(o_empty), 1);

    // Fill to 16, then stream push+pop while full across the pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1, 8'h50 + 8'(i), 0);
    for (int i = 0; i < 20; i++) step(1, 8'h70 + 8'(i), 1);
    step(0, 8'h00, 0);
    #1;
    chk("full_stream_count", int'(o_count), 16);
    chk("full_stream_ovf", int'(o_overflow), 0);
    chk("full_stream_head", int'(o_ascii), 8'h74);
    // The 17th push is dropped
    step(1, 8'h5a, 0);
    step(0, 8'h00, 0);
    #1;
    chk("ovf_full", int'(o_full), 1);
    chk("ovf_set", int'(o_overflow), 1);
    chk("ovf_count", int'(o_count), 16);
    // Drain: the model checks that 8'h5a never appears
    for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    #1;
    chk("ovf_sticky", int'(o_overflow), 1);
    do_sclr();
    #1;
    chk("sclr_ovf", int'(o_overflow), 0);
    chk("sclr_count", int'(o_count), 0);

    // Unmapped code is ignored
    step(1, 8'h00, 0);
    step(0, 8'h00, 0);
    #1;
    chk("nul_count", int'(o_count), 0);
    chk("nul_valid", int'(o_valid), 0);

    // Backspace
    step(1, 8'h61, 0);
    step(1, 8'h62, 0);
    step(1, 8'h08, 0);
    step(0, 8'h00, 0);
    #1;
`ifdef ASCII_FIFO_BS_EN
    chk("bs_count", int'(o_count), 1);
    chk("bs_head", int'(o_ascii), 8'h61);
    step(0, 8'h00, 1);
    step(1, 8'h08, 0);
    step(0, 8'h00, 0);
    #1;
    chk("bs_empty_count", int'(o_count), 1);
    chk("bs_empty_head", int'(o_ascii), 8'h08);
`else
    chk("bs_count", int'(o_count), 3);
    chk("bs_head", int'(o_ascii), 8'h61);
`endif
    do_sclr();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      c = 8'($urandom_range(32, 126));
      if (r < 5) c = 8'h00;
      else if (r < 15) c = 8'h08;
      if ($urandom_range(0, 199) == 0) begin
        do_sclr();
      end else begin
        // Alternate producer-heavy and consumer-heavy phases
        if (((i / 200) % 2) == 0)
          step(logic'($urandom_range(0, 3) != 0), c, logic'($urandom_range(0, 3) == 0));
        else
          step(logic'($urandom_range(0, 3) == 0), c, logic'($urandom_range(0, 3) != 0));
      end
    end

    // Asynchronous reset mid-stream with five entries
    do_sclr();
    for (int i = 0; i < 5; i++) step(1, 8'h30 + 8'(i), 0);
    step(0, 8'h00, 0);
    #1;
    chk("pre_arst_count", int'(o_count), 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_valid), 0);
    chk("arst_empty", int'(o_empty), 1);
    chk("arst_full", int'(o_full), 0);
    chk("arst_count", int'(o_count), 0);
    chk("arst_ascii", int'(o_ascii), 8'h00);
    chk("arst_ovf", int'(o_overflow), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 8'h21, 0);
    step(0, 8'h00, 0);
    #1;
    chk("post_arst_head", int'(o_ascii), 8'h21);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
